// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the branch-resolve / hazard controller and its BTB.
// Holds the PCSrc codes, the 2-bit predictor states and the sequential PC step.
package pipe_hazard_ctrl_pkg;

  typedef logic [1:0] pcsrc_t;
  typedef logic [1:0] ctr_t;

  localparam pcsrc_t PCSRC_NONE   = 2'b00;
  localparam pcsrc_t PCSRC_JAL    = 2'b01;
  localparam pcsrc_t PCSRC_JALR   = 2'b10;
  localparam pcsrc_t PCSRC_BRANCH = 2'b11;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  localparam int PC_STEP = 4;

  // Saturating 2-bit counter step; 00 and 11 hold their value.
  function automatic ctr_t ctr_step(input ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
// A lookup and an update of the same index in one cycle sees pre-update contents.
module btb_table
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  pcsrc_t          upd_pcsrc,
  input  logic [XLEN-3:0] upd_word,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic            ent_valid  [BTB_ENTRIES];
  logic            ent_jump   [BTB_ENTRIES];
  logic [TAG_W-1:0] ent_tag   [BTB_ENTRIES];
  logic [XLEN-1:0] ent_target [BTB_ENTRIES];
  ctr_t            ent_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[XLEN-1:IDX_W+2];
  assign lk_hit  = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && (ent_jump[lk_idx] || ent_ctr[lk_idx][1]);
  assign pred_target = pred_taken ? ent_target[lk_idx] : lookup_pc + XLEN'(PC_STEP);

  // upd_word is the resolving PC without its two byte-offset bits.
  assign upd_idx = upd_word[IDX_W-1:0];
  assign upd_tag = upd_word[XLEN-3:IDX_W];
  assign upd_hit = ent_valid[upd_idx] && (ent_tag[upd_idx] == upd_tag);

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
    logic             valid_reg;
    logic             jump_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [XLEN-1:0]  target_reg;
    ctr_t             ctr_reg;
    logic             sel;

    assign sel = upd_en && (upd_idx == IDX_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg  <= 1'b0;
        jump_reg   <= 1'b0;
        tag_reg    <= '0;
        target_reg <= '0;
        ctr_reg    <= CTR_SNT;
      end else if (sel) begin
        case (upd_pcsrc)
          PCSRC_JAL, PCSRC_JALR: begin
            valid_reg  <= 1'b1;
            jump_reg   <= 1'b1;
            tag_reg    <= upd_tag;
            target_reg <= upd_target;
            ctr_reg    <= CTR_ST;
          end
          PCSRC_BRANCH: begin
            if (upd_hit) begin
              jump_reg   <= 1'b0;
              target_reg <= upd_target;
              ctr_reg    <= ctr_step(ctr_reg, upd_taken);
            end else if (upd_taken) begin
              valid_reg  <= 1'b1;
              jump_reg   <= 1'b0;
              tag_reg    <= upd_tag;
              target_reg <= upd_target;
              ctr_reg    <= CTR_WT;
            end
          end
          default: begin
            // A non-control instruction owning this entry means the entry is stale.
            if (upd_hit) valid_reg <= 1'b0;
          end
        endcase
      end
    end

    assign ent_valid[gi]  = valid_reg;
    assign ent_jump[gi]   = jump_reg;
    assign ent_tag[gi]    = tag_reg;
    assign ent_target[gi] = target_reg;
    assign ent_ctr[gi]    = ctr_reg;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Control-hazard and load-use controller: mispredict redirect/flush, stall
// generation, BTB-based fetch prediction and resolve/mispredict counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [XLEN-1:0]  PC_IF,
  output logic             PRED_TAKEN,
  output logic [XLEN-1:0]  PRED_TARGET,
  input  logic             RES_VALID,
  input  logic [1:0]       PCSrc,
  input  logic             Branch_Cond,
  input  logic [XLEN-1:0]  PC_EXMEM,
  input  logic [XLEN-1:0]  ALUOUT_EXMEM,
  input  logic             PRED_TAKEN_EXMEM,
  input  logic [XLEN-1:0]  PRED_TARGET_EXMEM,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic [4:0]       RD_IDEX,
  input  logic             MemRead_IDEX,
  output logic [XLEN-1:0]  ALUOUT_PC,
  output logic             Hazard_Sig,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             FLUSH_EXMEM,
  output logic             STALL_PC,
  output logic             STALL_IFID,
  output logic             BUBBLE_IDEX,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] MISP_CNT
);

  logic            actual_taken;
  logic [XLEN-1:0] actual_target;
  logic            mispredict;
  logic            load_use;
  logic [CNT_W-1:0] br_cnt_reg;
  logic [CNT_W-1:0] misp_cnt_reg;

  assign actual_taken = (PCSrc == PCSRC_JAL) || (PCSrc == PCSRC_JALR) ||
                        ((PCSrc == PCSRC_BRANCH) && Branch_Cond);
  assign actual_target = (PCSrc == PCSRC_JALR) ? {ALUOUT_EXMEM[XLEN-1:1], 1'b0} : ALUOUT_EXMEM;

  assign mispredict = RES_VALID &&
                      ((PRED_TAKEN_EXMEM != actual_taken) ||
                       (actual_taken && (PRED_TARGET_EXMEM != actual_target)));

  assign Hazard_Sig  = mispredict;
  assign FLUSH_IFID  = mispredict;
  assign FLUSH_IDEX  = mispredict;
  assign FLUSH_EXMEM = mispredict;
  assign ALUOUT_PC   = !mispredict ? '0 :
                       actual_taken ? actual_target : PC_EXMEM + XLEN'(PC_STEP);

  // A redirect squashes the instructions the stall would otherwise hold.
  assign load_use = MemRead_IDEX && (RD_IDEX != 5'd0) &&
                    ((RD_IDEX == RS1_ID) || (RD_IDEX == RS2_ID));
  assign STALL_PC    = load_use && !mispredict;
  assign STALL_IFID  = load_use && !mispredict;
  assign BUBBLE_IDEX = load_use && !mispredict;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_cnt_reg   <= '0;
      misp_cnt_reg <= '0;
    end else begin
      if (RES_VALID && (PCSrc != PCSRC_NONE) && !(&br_cnt_reg))
        br_cnt_reg <= br_cnt_reg + 1'b1;
      if (mispredict && !(&misp_cnt_reg))
        misp_cnt_reg <= misp_cnt_reg + 1'b1;
    end
  end

  assign BR_CNT   = br_cnt_reg;
  assign MISP_CNT = misp_cnt_reg;

  btb_table #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (CLK),
    .rst         (RST),
    .lookup_pc   (PC_IF),
    .pred_taken  (PRED_TAKEN),
    .pred_target (PRED_TARGET),
    .upd_en      (RES_VALID),
    .upd_pcsrc   (PCSrc),
    .upd_word    (PC_EXMEM[XLEN-1:2]),
    .upd_taken   (actual_taken),
    .upd_target  (actual_target)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model
// that keeps the BTB as per-index records (owner PC, target, jump, counter value).
module tb_pipe_hazard_ctrl;

  localparam int XLEN        = 32;
  localparam int BTB_ENTRIES = 16;
  localparam int CNT_W       = 8;
  localparam int IDX_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [XLEN-1:0]  PC_IF;
  logic             PRED_TAKEN;
  logic [XLEN-1:0]  PRED_TARGET;
  logic             RES_VALID;
  logic [1:0]       PCSrc;
  logic             Branch_Cond;
  logic [XLEN-1:0]  PC_EXMEM;
  logic [XLEN-1:0]  ALUOUT_EXMEM;
  logic             PRED_TAKEN_EXMEM;
  logic [XLEN-1:0]  PRED_TARGET_EXMEM;
  logic [4:0]       RS1_ID;
  logic [4:0]       RS2_ID;
  logic [4:0]       RD_IDEX;
  logic             MemRead_IDEX;
  logic [XLEN-1:0]  ALUOUT_PC;
  logic             Hazard_Sig;
  logic             FLUSH_IFID;
  logic             FLUSH_IDEX;
  logic             FLUSH_EXMEM;
  logic             STALL_PC;
  logic             STALL_IFID;
  logic             BUBBLE_IDEX;
  logic [CNT_W-1:0] BR_CNT;
  logic [CNT_W-1:0] MISP_CNT;

  pipe_hazard_ctrl #(.XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .PC_IF(PC_IF), .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .RES_VALID(RES_VALID), .PCSrc(PCSrc), .Branch_Cond(Branch_Cond), .PC_EXMEM(PC_EXMEM),
    .ALUOUT_EXMEM(ALUOUT_EXMEM), .PRED_TAKEN_EXMEM(PRED_TAKEN_EXMEM),
    .PRED_TARGET_EXMEM(PRED_TARGET_EXMEM), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_IDEX(RD_IDEX),
    .MemRead_IDEX(MemRead_IDEX), .ALUOUT_PC(ALUOUT_PC), .Hazard_Sig(Hazard_Sig),
    .FLUSH_IFID(FLUSH_IFID), .FLUSH_IDEX(FLUSH_IDEX), .FLUSH_EXMEM(FLUSH_EXMEM),
    .STALL_PC(STALL_PC), .STALL_IFID(STALL_IFID), .BUBBLE_IDEX(BUBBLE_IDEX),
    .BR_CNT(BR_CNT), .MISP_CNT(MISP_CNT)
  );

  always #5 CLK = ~CLK;

  bit          m_valid  [BTB_ENTRIES];
  logic [31:0] m_owner  [BTB_ENTRIES];
  logic [31:0] m_target [BTB_ENTRIES];
  bit          m_jump   [BTB_ENTRIES];
  int          m_ctr    [BTB_ENTRIES];
  int          m_br;
  int          m_misp;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % BTB_ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && ((m_owner[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_hit(pc) && (m_jump[i] || m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_pred(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      m_valid[i] = 0; m_owner[i] = '0; m_target[i] = '0; m_jump[i] = 0; m_ctr[i] = 0;
    end
    m_br = 0;
    m_misp = 0;
  endtask

  task automatic idle();
    RES_VALID = 0; PCSrc = 2'b00; Branch_Cond = 0; PC_EXMEM = '0; ALUOUT_EXMEM = '0;
    PRED_TAKEN_EXMEM = 0; PRED_TARGET_EXMEM = '0; RS1_ID = '0; RS2_ID = '0; RD_IDEX = '0;
    MemRead_IDEX = 0;
  endtask

  task automatic set_res(input bit v, input logic [1:0] src, input bit cond, input logic [31:0] pc,
                         input logic [31:0] alu, input bit pt, input logic [31:0] ptgt);
    RES_VALID = v; PCSrc = src; Branch_Cond = cond; PC_EXMEM = pc; ALUOUT_EXMEM = alu;
    PRED_TAKEN_EXMEM = pt; PRED_TARGET_EXMEM = ptgt;
  endtask

  // One cycle: compare all outputs against the model, clock, then advance the model.
  task automatic step(input string name);
    bit          act_taken;
    logic [31:0] act_tgt;
    bit          misp;
    logic [31:0] redir;
    bit          lu;
    int          i;
    #1;
    act_taken = (PCSrc == 2'b01) || (PCSrc == 2'b10) || (PCSrc == 2'b11 && Branch_Cond);
    act_tgt   = (PCSrc == 2'b10) ? (ALUOUT_EXMEM & ~32'h1) : ALUOUT_EXMEM;
    misp = RES_VALID && ((PRED_TAKEN_EXMEM != act_taken) ||
                         (act_taken && PRED_TARGET_EXMEM != act_tgt));
    redir = !misp ? 32'd0 : (act_taken ? act_tgt : PC_EXMEM + 32'd4);
    lu = MemRead_IDEX && RD_IDEX != 0 && (RD_IDEX == RS1_ID || RD_IDEX == RS2_ID) && !misp;
    chk({name, ".pred_taken"}, PRED_TAKEN, m_pred(PC_IF));
    chk({name, ".pred_target"}, PRED_TARGET, m_pred_tgt(PC_IF));
    chk({name, ".hazard"}, Hazard_Sig, misp);
    chk({name, ".redirect"}, ALUOUT_PC, redir);
    chk({name, ".flush"}, {FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM}, {3{misp}});
    chk({name, ".stall"}, {STALL_PC, STALL_IFID, BUBBLE_IDEX}, {3{lu}});
    chk({name, ".br_cnt"}, BR_CNT, m_br);
    chk({name, ".misp_cnt"}, MISP_CNT, m_misp);
    $display("txn %s: v=%0d src=%0d pc=%h alu=%h misp=%0d redir=%h stall=%0d br=%0d mp=%0d",
             name, RES_VALID, PCSrc, PC_EXMEM, ALUOUT_EXMEM, misp, redir, lu, m_br, m_misp);
    @(posedge CLK);
    if (!RST && RES_VALID) begin
      i = idx_of(PC_EXMEM);
      case (PCSrc)
        2'b01, 2'b10: begin
          m_valid[i] = 1; m_owner[i] = PC_EXMEM; m_target[i] = act_tgt; m_jump[i] = 1; m_ctr[i] = 3;
        end
        2'b11: begin
          if (m_hit(PC_EXMEM)) begin
            m_ctr[i] = act_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                 : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            m_target[i] = act_tgt;
            m_jump[i] = 0;
          end else if (act_taken) begin
            m_valid[i] = 1; m_owner[i] = PC_EXMEM; m_target[i] = act_tgt; m_jump[i] = 0; m_ctr[i] = 2;
          end
        end
        default: if (m_hit(PC_EXMEM)) m_valid[i] = 0;
      endcase
      if (PCSrc != 2'b00 && m_br < CNT_MAX) m_br++;
      if (misp && m_misp < CNT_MAX) m_misp++;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1;
    m_clear();
    #1;
    chk("reset.br_cnt", BR_CNT, 0);
    chk("reset.misp_cnt", MISP_CNT, 0);
    @(posedge CLK);
    #1;
    RST = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc = 32'($urandom_range(0, 31)) << 2;
    if ($urandom_range(0, 3) == 0) pc = pc | 32'h1000;
    return pc;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    PC_IF = 32'h100;
    RST = 0;
    #2;
    do_reset();

    // JAL predicted not-taken redirects and trains the BTB
    chk("empty.pred_taken", PRED_TAKEN, 0);
    chk("empty.pred_target", PRED_TARGET, 32'h104);
    set_res(1, 2'b01, 0, 32'h100, 32'h200, 0, 32'h104);
    #1;
    chk("jal.redirect", ALUOUT_PC, 32'h200);
    step("jal");
    idle();
    PC_IF = 32'h100;
    #1;
    chk("jal.trained_taken", PRED_TAKEN, 1);
    chk("jal.trained_target", PRED_TARGET, 32'h200);
    step("jal_lookup");

    // JALR target bit 0 cleared before comparing with the prediction
    set_res(1, 2'b10, 0, 32'h10, 32'h305, 1, 32'h304);
    #1;
    chk("jalr.hit_hazard", Hazard_Sig, 0);
    step("jalr_ok");
    set_res(1, 2'b10, 0, 32'h10, 32'h305, 1, 32'h300);
    #1;
    chk("jalr.miss_redirect", ALUOUT_PC, 32'h304);
    step("jalr_bad");

    // Branch at 0x40: taken x3 then not-taken
    idle();
    do_reset();
    PC_IF = 32'h40;
    set_res(1, 2'b11, 1, 32'h40, 32'h20, 1, 32'h20);
    step("br1");
    for (int k = 0; k < 3; k++) begin
      set_res(1, 2'b11, (k < 2), 32'h40, 32'h20, PRED_TAKEN, PRED_TARGET);
      #1;
      chk("br.pred_taken", PRED_TAKEN, 1);
      if (k == 2) chk("br.nt_redirect", ALUOUT_PC, 32'h44);
      step("br");
    end
    idle();
    #1;
    chk("br.after_nt_taken", PRED_TAKEN, 1);
    chk("br.misp_cnt", MISP_CNT, 1);
    chk("br.br_cnt", BR_CNT, 4);
    step("br_done");

    // Load-use stall and redirect priority
    MemRead_IDEX = 1; RD_IDEX = 5; RS1_ID = 1; RS2_ID = 5;
    #1;
    chk("lu.stall", {STALL_PC, STALL_IFID, BUBBLE_IDEX}, 3'b111);
    step("lu");
    RD_IDEX = 0; RS2_ID = 0;
    #1;
    chk("lu.x0", {STALL_PC, STALL_IFID, BUBBLE_IDEX}, 3'b000);
    step("lu_x0");
    RD_IDEX = 5; RS2_ID = 5;
    set_res(1, 2'b01, 0, 32'h60, 32'h700, 0, 32'h64);
    #1;
    chk("lu.misp_stall", {STALL_PC, STALL_IFID, BUBBLE_IDEX}, 3'b000);
    chk("lu.misp_flush", {FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM}, 3'b111);
    step("lu_misp");

    // Non-control instruction predicted taken: aliasing PC, then owning PC
    idle();
    set_res(1, 2'b01, 0, 32'h80, 32'h500, 0, 32'h84);
    step("own80");
    set_res(1, 2'b00, 0, 32'h1080, 32'h0, 1, 32'h500);
    #1;
    chk("alias.redirect", ALUOUT_PC, 32'h1084);
    step("alias");
    PC_IF = 32'h80;
    set_res(1, 2'b00, 0, 32'h80, 32'h0, 1, 32'h500);
    #1;
    chk("alias.entry_kept", PRED_TAKEN, 1);
    chk("nonctl.redirect", ALUOUT_PC, 32'h84);
    step("nonctl");
    idle();
    #1;
    chk("nonctl.invalidated", PRED_TAKEN, 0);
    step("nonctl_lookup");

    // Reset mid-resolve drops the pending update
    set_res(1, 2'b01, 0, 32'h80, 32'h900, 0, 32'h84);
    PC_IF = 32'h100;
    #2;
    RST = 1;
    m_clear();
    #1;
    chk("rst_mid.pred", PRED_TAKEN, 0);
    chk("rst_mid.br_cnt", BR_CNT, 0);
    @(posedge CLK);
    #1;
    RST = 0;
    idle();
    PC_IF = 32'h80;
    step("post_rst_lookup");
    set_res(1, 2'b01, 0, 32'h80, 32'h900, 0, 32'h84);
    step("post_rst_update");
    idle();
    #1;
    chk("post_rst.trained", PRED_TARGET, 32'h900);
    step("post_rst_check");

    // Randomized traffic, predictions carried from the model or scrambled
    for (int n = 0; n < 600; n++) begin
      PC_IF = rand_pc();
      RES_VALID = ($urandom_range(0, 9) < 8);
      PCSrc = 2'($urandom_range(0, 3));
      Branch_Cond = 1'($urandom_range(0, 1));
      PC_EXMEM = rand_pc();
      ALUOUT_EXMEM = rand_pc() | 32'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        PRED_TAKEN_EXMEM = m_pred(PC_EXMEM);
        PRED_TARGET_EXMEM = m_pred_tgt(PC_EXMEM);
      end else begin
        PRED_TAKEN_EXMEM = 1'($urandom_range(0, 1));
        PRED_TARGET_EXMEM = rand_pc();
      end
      MemRead_IDEX = 1'($urandom_range(0, 1));
      RD_IDEX = 5'($urandom_range(0, 3));
      RS1_ID = 5'($urandom_range(0, 3));
      RS2_ID = 5'($urandom_range(0, 3));
      if (n == 300) begin
        #2;
        RST = 1;
        m_clear();
        @(posedge CLK);
        #1;
        RST = 0;
      end
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
